ps2_host_tx: RTL and testbench

Host-to-device transmitter for the PS/2 port: it sends one command byte (LED set, reset, typematic rate) to the keyboard. It sits beside the keyboard receiver on the same two open-drain pads, runs entirely on `system_clk`, and drives the pads only by pulling them low. While a frame is in flight it raises `tx_active` so the receiver ignores device-generated clocks.

---
 rtl/ps2_host_tx.sv | 162 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device-generated clocks and checks the device ACK.
module ps2_host_tx #(
    parameter int CLK_HOLD_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES  = 750000
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic       PS2_clk_drive_low,
    output logic       PS2_data_drive_low,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] debug_state
);

    // Handshake: a byte transfers on any cycle where tx_valid && tx_ready;
    // tx_ready is high only in IDLE, and tx_valid at any other time is dropped.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQUEST   = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam int HOLD_W = (CLK_HOLD_CYCLES > 1) ? $clog2(CLK_HOLD_CYCLES) : 1;
    localparam int TOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLK_HOLD_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TOUT_W-1:0] tout_cnt;
    logic [3:0]        bit_idx;
    logic [9:0]        frame;

    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync;
    logic fall;

    // Idle-high reset values keep a spurious fall from appearing after reset.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= PS2_data;
            dat_sync <= dat_meta;
        end
    end

    assign fall        = clk_prev & ~clk_sync;
    assign debug_state = state;

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            hold_cnt           <= '0;
            tout_cnt           <= '0;
            bit_idx            <= '0;
            frame              <= '1;
            tx_ready           <= 1'b1;
            tx_active          <= 1'b0;
            tx_done            <= 1'b0;
            tx_error           <= 1'b0;
            PS2_clk_drive_low  <= 1'b0;
            PS2_data_drive_low <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        // frame[0] is the bit currently on the line: start, d0..d7, odd parity, stop.
                        frame             <= {1'b1, ~^tx_data, tx_data, 1'b0};
                        hold_cnt          <= '0;
                        state             <= INHIBIT;
                        tx_ready          <= 1'b0;
                        tx_active         <= 1'b1;
                        PS2_clk_drive_low <= 1'b1;
                    end
                end
                INHIBIT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state              <= REQUEST;
                        PS2_data_drive_low <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                REQUEST: begin
                    state              <= SEND;
                    bit_idx            <= '0;
                    tout_cnt           <= '0;
                    PS2_clk_drive_low  <= 1'b0;
                    PS2_data_drive_low <= ~frame[0];
                end
                SEND, ACK: begin
                    if (tout_cnt == TOUT_LAST) begin
                        state              <= IDLE;
                        tx_error           <= 1'b1;
                        tx_ready           <= 1'b1;
                        tx_active          <= 1'b0;
                        PS2_clk_drive_low  <= 1'b0;
                        PS2_data_drive_low <= 1'b0;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                        if (fall && state == SEND) begin
                            if (bit_idx == 4'd9) begin
                                state              <= ACK;
                                PS2_data_drive_low <= 1'b0;
                            end else begin
                                bit_idx            <= bit_idx + 1'b1;
                                frame              <= {1'b1, frame[9:1]};
                                PS2_data_drive_low <= ~frame[1];
                            end
                        end else if (fall) begin
                            if (dat_sync) begin
                                state     <= IDLE;
                                tx_error  <= 1'b1;
                                tx_ready  <= 1'b1;
                                tx_active <= 1'b0;
                            end else begin
                                state <= WAIT_IDLE;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync && dat_sync) begin
                        state     <= IDLE;
                        tx_done   <= 1'b1;
                        tx_ready  <= 1'b1;
                        tx_active <= 1'b0;
                    end
                end
                default: begin
                    state              <= IDLE;
                    tx_ready           <= 1'b1;
                    tx_active          <= 1'b0;
                    PS2_clk_drive_low  <= 1'b0;
                    PS2_data_drive_low <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// transmitter while table vectors and hand sequences check bits, pulses and timing.
module tb_ps2_host_tx;

    localparam int HOLD = 8;
    localparam int TOUT = 100;

    logic       system_clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       PS2_clk;
    logic       PS2_data;
    logic       PS2_clk_drive_low;
    logic       PS2_data_drive_low;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;
    logic [2:0] debug_state;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    // Open-drain pads: low if either side pulls.
    assign PS2_clk  = ~(PS2_clk_drive_low | dev_clk_low);
    assign PS2_data = ~(PS2_data_drive_low | dev_data_low);

    ps2_host_tx #(
        .CLK_HOLD_CYCLES (HOLD),
        .TIMEOUT_CYCLES  (TOUT)
    ) dut (
        .system_clk         (system_clk),
        .reset              (reset),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .PS2_clk            (PS2_clk),
        .PS2_data           (PS2_data),
        .PS2_clk_drive_low  (PS2_clk_drive_low),
        .PS2_data_drive_low (PS2_data_drive_low),
        .tx_active          (tx_active),
        .tx_done            (tx_done),
        .tx_error           (tx_error),
        .debug_state        (debug_state)
    );

    always #5 system_clk = ~system_clk;

    typedef struct {
        logic [7:0] data;
        logic       ack_low;
        logic       par;
        int         exp_done;
        int         exp_error;
    } vec_t;

    vec_t vecs[7];

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;

    always @(negedge system_clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        while (!tx_ready && w < 200) begin
            tick();
            w++;
        end
        check("ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Waits for the first SEND cycle: clock released, start bit driven.
    task automatic wait_send();
        int w = 0;
        while (!(tx_active && !PS2_clk_drive_low && PS2_data_drive_low) && w < 100) begin
            tick();
            w++;
        end
        check("send_entry", {tx_active, PS2_clk_drive_low, PS2_data_drive_low}, 3'b101);
    endtask

    // Device model: low 5 cycles, high 3 cycles; line sampled just before each rise.
    task automatic device_frame(input logic ack_low, input int nclk, output logic [10:0] seen);
        seen    = '1;
        seen[0] = PS2_data;
        tick();
        tick();
        for (int k = 1; k <= nclk; k++) begin
            dev_clk_low = 1'b1;
            if (k == 11 && ack_low) dev_data_low = 1'b1;
            repeat (4) tick();
            if (k <= 10) seen[k] = PS2_data;
            tick();
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            repeat (3) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] seen;
        logic [10:0] exp_frame;
        int          d0, e0, hold, cnt;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'hF4, 1'b0, 1'b0, 0, 1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1, 0};
        vecs[3] = '{8'h7F, 1'b0, 1'b0, 0, 1};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1, 0};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 1, 0};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 0, 1};

        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        check("rst_clk_drive", PS2_clk_drive_low, 0);
        check("rst_data_drive", PS2_data_drive_low, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_active", tx_active, 0);
        check("rst_pulses", {tx_done, tx_error}, 0);
        check("rst_state", debug_state, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Hold timing, 0xED frame, and a new byte accepted during tx_done.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hED);
        check("inhibit_ready_active", {tx_ready, tx_active}, 2'b01);
        hold = 0;
        while (PS2_clk_drive_low && !PS2_data_drive_low && hold < 50) begin
            hold++;
            tick();
        end
        check("hold_cycles", hold, HOLD);
        check("request_drives", {PS2_clk_drive_low, PS2_data_drive_low}, 2'b11);
        tick();
        check("release_data_low", {PS2_clk_drive_low, PS2_data_drive_low}, 2'b01);
        wait_send();
        device_frame(1'b1, 11, seen);
        check("frame_ED", seen, {1'b1, 1'b1, 8'hED, 1'b0});
        check("done_with_ready", {tx_done, tx_ready}, 2'b11);
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("b2b_accept", {tx_active, PS2_clk_drive_low, tx_ready}, 3'b110);
        wait_send();
        device_frame(1'b1, 11, seen);
        check("frame_81", seen, {1'b1, 1'b1, 8'h81, 1'b0});
        repeat (4) tick();
        check("seqA_done", done_cnt - d0, 2);
        check("seqA_error", err_cnt - e0, 0);

        // tx_valid with 0xFF during INHIBIT must be ignored.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h5A);
        tick();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        wait_send();
        device_frame(1'b1, 11, seen);
        check("frame_5A_kept", seen, {1'b1, 1'b1, 8'h5A, 1'b0});
        repeat (6) tick();
        check("ignore_done_once", done_cnt - d0, 1);
        check("ignore_no_error", err_cnt - e0, 0);

        // Device never clocks: error exactly TOUT cycles after SEND entry.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h55);
        wait_send();
        cnt = 0;
        while (!tx_error && cnt < 300) begin
            tick();
            cnt++;
        end
        check("timeout_cycles", cnt, TOUT);
        check("timeout_drives", {PS2_clk_drive_low, PS2_data_drive_low}, 2'b00);
        check("timeout_ready", {tx_ready, tx_active}, 2'b10);
        tick();
        check("timeout_pulse_width", tx_error, 0);
        check("timeout_err_cnt", err_cnt - e0, 1);
        check("timeout_no_done", done_cnt - d0, 0);

        // Reset mid-frame after the 4th data bit (d3 = 0 on the line).
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hE7);
        wait_send();
        device_frame(1'b1, 4, seen);
        check("pre_reset_data_drive", {tx_active, PS2_data_drive_low}, 2'b11);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_release", {PS2_clk_drive_low, PS2_data_drive_low, tx_active}, 3'b000);
        check("reset_ready", tx_ready, 1);
        tick();
        tick();
        reset = 1'b1;
        repeat (2) tick();
        check("reset_no_error", err_cnt - e0, 0);
        send_byte(8'h00);
        wait_send();
        device_frame(1'b1, 11, seen);
        check("frame_00_after_reset", seen, {1'b1, 1'b1, 8'h00, 1'b0});
        repeat (4) tick();
        check("after_reset_done", done_cnt - d0, 1);

        // Table-driven frames with ACKing and NACKing device.
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_byte(vecs[i].data);
            wait_send();
            device_frame(vecs[i].ack_low, 11, seen);
            repeat (4) tick();
            exp_frame = {1'b1, vecs[i].par, vecs[i].data, 1'b0};
            check($sformatf("vec%0d_frame", i), seen, exp_frame);
            check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("vec%0d_error", i), err_cnt - e0, vecs[i].exp_error);
            check($sformatf("vec%0d_idle", i),
                  {PS2_clk_drive_low, PS2_data_drive_low, tx_ready, tx_active}, 4'b0010);
        end
        check("done_error_never_together", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
